// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM encoding,
// default multiply latency and a conditional two's-complement helper.
package mdu_pkg;

  localparam int unsigned MDU_MUL_LAT = 5;

  localparam logic [2:0] MDU_MULT  = 3'd0;
  localparam logic [2:0] MDU_MULTU = 3'd1;
  localparam logic [2:0] MDU_DIV   = 3'd2;
  localparam logic [2:0] MDU_DIVU  = 3'd3;
  localparam logic [2:0] MDU_MTHI  = 3'd4;
  localparam logic [2:0] MDU_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } mdu_state_e;

  function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
    logic [31:0] r;
    if (neg) begin
      r = 32'd0 - v;
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/mdu_div.sv
// Iterative radix-2 restoring divider on 32-bit magnitudes. One quotient bit
// per cycle for 32 cycles after load; done flags the cycle of the final step.
module mdu_div
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        run_q, run_d;
  logic [32:0] shifted_s;
  logic [32:0] diff_s;
  logic        ge_s;

  // Since rem < divisor, the shifted remainder minus divisor fits in 33 bits
  // with bit 32 acting as the borrow.
  always_comb begin
    quot_d    = quot_q;
    rem_d     = rem_q;
    dvsr_d    = dvsr_q;
    cnt_d     = cnt_q;
    run_d     = run_q;
    shifted_s = {rem_q, quot_q[31]};
    diff_s    = shifted_s - {1'b0, dvsr_q};
    ge_s      = ~diff_s[32];
    if (load) begin
      quot_d = dividend;
      rem_d  = 32'd0;
      dvsr_d = divisor;
      cnt_d  = 5'd31;
      run_d  = 1'b1;
    end else if (run_q) begin
      quot_d = {quot_q[30:0], ge_s};
      if (ge_s) begin
        rem_d = diff_s[31:0];
      end else begin
        rem_d = shifted_s[31:0];
      end
      if (cnt_q == 5'd0) begin
        run_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 5'd1;
      end
    end else begin
      run_d = 1'b0;
    end
  end

  // Divider state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      quot_q <= 32'd0;
      rem_q  <= 32'd0;
      dvsr_q <= 32'd0;
      cnt_q  <= 5'd0;
      run_q  <= 1'b0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dvsr_q <= dvsr_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
    end
  end

  assign done = run_q && (cnt_q == 5'd0);
  assign quot = quot_q;
  assign rem  = rem_q;

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers. Multiply result lands MUL_LAT
// cycles after acceptance; divide takes 32 step cycles plus one sign-fix cycle.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MUL_LAT = MDU_MUL_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      prod_q, prod_d, prod_s;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;

  logic             sdiv_s, a_neg_s, b_neg_s, mul_sext_s;
  logic             div_load_s, div_done_s;
  logic [31:0]      mag_a_s, mag_b_s, quot_s, rem_s;
  logic [63:0]      opa_s, opb_s;

  // Operand conditioning: sign-extend for MULT, take magnitudes for DIV.
  always_comb begin
    sdiv_s     = (op == MDU_DIV);
    mul_sext_s = (op == MDU_MULT);
    a_neg_s    = sdiv_s & a[31];
    b_neg_s    = sdiv_s & b[31];
    mag_a_s    = cond_neg(a, a_neg_s);
    mag_b_s    = cond_neg(b, b_neg_s);
    opa_s      = {{32{mul_sext_s & a[31]}}, a};
    opb_s      = {{32{mul_sext_s & b[31]}}, b};
    prod_s     = opa_s * opb_s;
    div_load_s = (state_q == ST_IDLE) && start &&
                 ((op == MDU_DIV) || (op == MDU_DIVU)) && (b != 32'd0);
  end

  mdu_div u_div (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load_s),
    .dividend (mag_a_s),
    .divisor  (mag_b_s),
    .done     (div_done_s),
    .quot     (quot_s),
    .rem      (rem_s)
  );

  // Next-state, HI/LO update and busy computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (op)
            MDU_MULT, MDU_MULTU: begin
              prod_d  = prod_s;
              cnt_d   = CNT_W'(MUL_LAT - 1);
              state_d = ST_MUL;
            end
            MDU_DIV, MDU_DIVU: begin
              if (div_load_s) begin
                qneg_d  = a_neg_s ^ b_neg_s;
                rneg_d  = a_neg_s;
                state_d = ST_DIV;
              end else begin
                state_d = ST_IDLE;
              end
            end
            MDU_MTHI: hi_d = a;
            MDU_MTLO: lo_d = a;
            default:  state_d = ST_IDLE;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (cnt_q == {CNT_W{1'b0}}) begin
          hi_d    = prod_q[63:32];
          lo_d    = prod_q[31:0];
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DIV: begin
        if (div_done_s) begin
          state_d = ST_FIX;
        end else begin
          state_d = ST_DIV;
        end
      end
      ST_FIX: begin
        lo_d    = cond_neg(quot_s, qneg_q);
        hi_d    = cond_neg(rem_s, rneg_q);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Architectural and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      prod_q  <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: a cycle-level reference model of HI/LO/busy checked
// every cycle, plus hand-computed literal checks after each scenario.
module tb_mdu;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  mdu #(.MUL_LAT(LAT)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // Reference model: remaining busy cycles and pending {hi,lo} result.
  int          m_left = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;
  logic [63:0] m_res = 64'd0;

  function automatic logic [63:0] model_res(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    longint q, r;
    case (o)
      3'd0: p = longint'($signed(x)) * longint'($signed(y));
      3'd1: p = {32'd0, x} * {32'd0, y};
      3'd2: begin
        q = longint'($signed(x)) / longint'($signed(y));
        r = longint'($signed(x)) % longint'($signed(y));
        p = {r[31:0], q[31:0]};
      end
      default: p = {x % y, x / y};
    endcase
    return p;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0;
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_hi <= m_res[63:32];
        m_lo <= m_res[31:0];
      end
    end else if (start) begin
      if (op == 3'd0 || op == 3'd1) begin
        m_res  <= model_res(op, a, b);
        m_left <= LAT;
      end else if ((op == 3'd2 || op == 3'd3) && b != 32'd0) begin
        m_res  <= model_res(op, a, b);
        m_left <= 33;
      end else if (op == 3'd4) begin
        m_hi <= a;
      end else if (op == 3'd5) begin
        m_lo <= a;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", {31'd0, busy}, {31'd0, (m_left > 0)});
      chk("cyc_hi", hi, m_hi);
      chk("cyc_lo", lo, m_lo);
    end
  end

  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts negedges with busy high, starting at the current one; bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: busy still %b after %0d cycles", busy, n);
    end
  endtask

  int n;

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);

    do_op(3'd0, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    chk("mult_busy_cycles", n, 32'd5);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);

    do_op(3'd1, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    chk("multu_hi", hi, 32'h00000002);
    chk("multu_lo", lo, 32'hFFFFFFFA);

    do_op(3'd2, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    chk("div_busy_cycles", n, 32'd33);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    do_op(3'd3, 32'd100, 32'd7);
    wait_idle(n);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    do_op(3'd4, 32'h11, 32'd0);
    do_op(3'd5, 32'h22, 32'd0);
    do_op(3'd2, 32'd5, 32'd0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      if (busy !== 1'b0) n++;
      @(negedge clk);
    end
    chk("div0_busy", n, 32'd0);
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);

    do_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
    wait_idle(n);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'h00000000);

    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'hDEADBEEF;
    @(negedge clk);
    chk("mthi_hi", hi, 32'hDEADBEEF);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    op = 3'd5; a = 32'h12345678;
    @(negedge clk);
    start = 1'b0;
    chk("mtlo_lo", lo, 32'h12345678);
    chk("mtlo_hi", hi, 32'hDEADBEEF);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);

    do_op(3'd3, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_hi", hi, 32'd0);
    chk("rst_mid_lo", lo, 32'd0);
    do_op(3'd0, 32'd3, 32'd4);
    wait_idle(n);
    chk("post_rst_lo", lo, 32'd12);
    chk("post_rst_hi", hi, 32'd0);

    do_op(3'd2, 32'hFFFFFC18, 32'd10);
    @(negedge clk);
    start = 1'b1; op = 3'd0; a = 32'd7; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_idle(n);
    chk("ignored_start_busy", n, 32'd31);
    chk("ignored_start_lo", lo, 32'hFFFFFF9C);
    chk("ignored_start_hi", hi, 32'd0);
    repeat (8) @(negedge clk);
    chk("no_late_mul_lo", lo, 32'hFFFFFF9C);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit sitting beside the ALU in the EX stage of the 5-stage pipeline. It takes the forwarded EX operands and executes MULT/MULTU/DIV/DIVU/MTHI/MTLO. It holds the HI/LO architectural registers, which MFHI/MFLO read through the EX result path. It exposes `busy` so the hazard unit can stall decode while an operation is in flight.

## Interface
- `MUL_LAT`, default 5: cycles from multiply acceptance to HI/LO update.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  EX-stage instruction is an MDU op. Already gated to 0 by `flushE`.
- `op`  in  3  operation code (package constants).
- `a`  in  32  forwarded rs operand (pre-shamt mux).
- `b`  in  32  forwarded rt operand (pre-imm mux).
- `busy`  out  1  registered; operation in flight.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- Reset: state IDLE, `busy`=0, `hi`=0, `lo`=0, counter=0. Reset mid-operation aborts the operation with no HI/LO update.
- States: IDLE, MUL, DIV, FIX.
- IDLE + `start`:
  - MULT/MULTU: latch the 64-bit signed/unsigned product into a result register, counter=`MUL_LAT`-1, go to MUL.
  - DIV/DIVU with `b`≠0: latch |a|, |b| (signed) or raw values (unsigned), plus the sign flags. Counter=31, go to DIV.
  - DIV/DIVU with `b`=0: no state change, `busy` stays 0, HI/LO unchanged.
  - MTHI: `hi`←`a` at this edge. MTLO: `lo`←`a` at this edge. Stay IDLE.
  - Undefined `op`: ignored.
- MUL: decrement counter. At counter=0, `hi`←product[63:32], `lo`←product[31:0], go to IDLE.
- DIV: one radix-2 restoring step per cycle (shift remainder/quotient left, trial subtract, set quotient bit). Decrement counter. After the step at counter=0, go to FIX.
- FIX (one cycle):
  - Quotient negated if sign(a)≠sign(b). Remainder takes the sign of `a`.
  - Write `lo`←quotient, `hi`←remainder. Go to IDLE.
- `start` while not IDLE: ignored. The hazard unit guarantees this cannot occur; the bench checks it anyway.
- Arithmetic rules:
  - DIV 0x80000000 / 0xFFFFFFFF: `lo`=0x80000000, `hi`=0.
  - All arithmetic is mod 2^32 per half.

## Timing
- `start` is sampled at edge E0.
- Multiply:
  - `busy`=1 after E0 through edge E0+`MUL_LAT`.
  - HI/LO update and `busy` fall together at that edge.
  - Default: first readable 5 cycles after acceptance.
- Divide:
  - 32 DIV cycles plus 1 FIX cycle.
  - HI/LO update and `busy` fall at E0+33.
- MTHI/MTLO: visible the cycle after E0; `busy` never rises.
- Hazard rule (outside this block): stall D/F and flush E when the D instruction is any MDU op or MFHI/MFLO and (`start` | `busy`). A following MFHI therefore always reads the updated value.
- `hi`/`lo` outputs are direct register outputs with no combinational path from inputs.

## Structure
- Shared package `mdu_pkg`:
  - Op constants: MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MTHI=4, MDU_MTLO=5.
  - State encoding.
  - `MUL_LAT` default.
- One sub-module: `mdu_div`, the iterative restoring divider core.
  - Ports: `clk`, `rst`, `load`, `dividend`, `divisor`, `done`, `quot`, `rem`.
  - Holds magnitudes and the step counter.
  - `mdu` owns sign handling, the FIX state and HI/LO.
- The multiplier product uses the synthesis `*` operator, registered once at acceptance.

## Test plan
- MULT a=0xFFFFFFFE (−2), b=3: `busy` high 5 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. MULTU with the same operands: `hi`=0x00000002, `lo`=0xFFFFFFFA.
- DIV a=−7 (0xFFFFFFF9), b=2: `busy` high 33 cycles, then `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU a=100, b=7: `lo`=14, `hi`=2.
- DIV by zero (a=5, b=0) with prior `hi`=0x11, `lo`=0x22: `busy` stays 0, HI/LO unchanged. Overflow case DIV 0x80000000 / −1: `lo`=0x80000000, `hi`=0.
- MTHI a=0xDEADBEEF, then MTLO a=0x12345678 on consecutive cycles: `hi`/`lo` show the values the cycle after each edge, `busy`=0 throughout.
- Reset asserted 10 cycles into a DIV: next cycle `busy`=0, `hi`=`lo`=0. A new MULT 3×4 then completes normally with `lo`=12.
- Second `start` (MULT) pulsed 2 cycles into a DIV: ignored. DIV result written at E0+33, no multiply result ever appears.
